gpio_pin_arbiter: RTL and testbench

//  Shares GPIO pad outputs between NumReq hardware requesters and the GPIO register path.
//  A requester claims a pin mask and gets exclusive ownership of out/oe for those pins.

---
 rtl/gpio_arb_pkg.sv | 10 +
 rtl/gpio_pin_arbiter_rr_pick.sv | 26 ++
 rtl/gpio_pin_arbiter.sv | 85 ++++++++
 tb/tb_gpio_pin_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/gpio_arb_pkg.sv
// gpio_arb_pkg: shared state type and index helpers for the GPIO pin arbiter
package gpio_arb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, OWN, BLOCK} arb_state_e;
  function automatic int req_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int rr_next(input int k, input int n);
    return (k + 1) % n;
  endfunction
endpackage

// File: rtl/gpio_pin_arbiter_rr_pick.sv
// gpio_pin_arbiter_rr_pick: round-robin winner among eligible requesters, search starting at ptr
module gpio_pin_arbiter_rr_pick #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] cand [N];
  for (genvar j = 0; j < N; j++) begin : g_cand
    assign cand[j] = IW'((int'(ptr) + j) % N);
  end
  always_comb begin
    valid = 1'b0;
    idx = '0;
    for (int j = 0; j < N; j++)
      if (!valid && eligible[cand[j]]) begin
        valid = 1'b1;
        idx = cand[j];
      end
    onehot = valid ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/gpio_pin_arbiter.sv
// gpio_pin_arbiter: grants exclusive pin masks to hardware requesters, software drives all unowned pins
module gpio_pin_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int NumReq = 4,
  parameter int Width = 32,
  parameter int TimeoutCycles = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumReq-1:0]       req_i,
  input  logic [NumReq*Width-1:0] req_mask_i,
  input  logic [NumReq-1:0]       rel_i,
  input  logic [NumReq*Width-1:0] req_out_i,
  input  logic [NumReq*Width-1:0] req_oe_i,
  input  logic [Width-1:0]        sw_out_i,
  input  logic [Width-1:0]        sw_oe_i,
  output logic [NumReq-1:0]       gnt_o,
  output logic [NumReq-1:0]       revoke_o,
  output logic [Width-1:0]        owned_mask_o,
  output logic [Width-1:0]        gpio_out_o,
  output logic [Width-1:0]        gpio_oe_o
);
  localparam int IW = req_idx_w(NumReq);
  localparam int CW = TimeoutCycles > 0 ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CW-1:0] Lim = CW'(TimeoutCycles > 0 ? TimeoutCycles - 1 : 0);
  localparam logic [CW-1:0] Sat = '1;
  logic [NumReq-1:0] eligible, win;
  logic [NumReq-1:0][Width-1:0] sel;
  logic [IW-1:0] ptr_q, win_idx;
  logic win_valid;
  logic [Width-1:0] owned, drv_out, drv_oe;
  gpio_pin_arbiter_rr_pick #(.N(NumReq), .IW(IW)) u_pick (
    .eligible(eligible),
    .ptr(ptr_q),
    .valid(win_valid),
    .onehot(win),
    .idx(win_idx)
  );
  for (genvar i = 0; i < NumReq; i++) begin : g_req
    arb_state_e state_q, state_d;
    logic [Width-1:0] mask_q;
    logic [CW-1:0] cnt_q;
    logic revoke_q, timeout;
    assign timeout = TimeoutCycles > 0 && cnt_q == Lim;
    always_comb
      state_d = state_q == IDLE ? (req_i[i] && |req_mask_i[i*Width +: Width] ? WAIT : IDLE)
              : state_q == WAIT ? (!req_i[i] ? IDLE : win[i] ? OWN : WAIT)
              : state_q == OWN  ? (rel_i[i] ? IDLE : timeout ? BLOCK : OWN)
              : (req_i[i] ? BLOCK : IDLE);
    always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
        state_q <= IDLE;
        mask_q <= '0;
        cnt_q <= '0;
        revoke_q <= 1'b0;
      end else begin
        state_q <= state_d;
        if (state_q == IDLE && state_d == WAIT) mask_q <= req_mask_i[i*Width +: Width];
        cnt_q <= state_q != OWN ? '0 : cnt_q == Sat ? cnt_q : cnt_q + 1'b1;
        revoke_q <= state_q == OWN && state_d == BLOCK;
      end
    // owned is derived from registered state, so a pin freed this cycle is only grantable next cycle
    assign eligible[i] = state_q == WAIT && req_i[i] && (mask_q & owned) == '0;
    assign sel[i] = state_q == OWN ? mask_q : '0;
    assign gnt_o[i] = state_q == OWN;
    assign revoke_o[i] = revoke_q;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) ptr_q <= '0;
    else if (win_valid) ptr_q <= IW'(rr_next(int'(win_idx), NumReq));
  always_comb begin
    owned = '0;
    drv_out = '0;
    drv_oe = '0;
    for (int i = 0; i < NumReq; i++) begin
      owned = owned | sel[i];
      drv_out = drv_out | (sel[i] & req_out_i[i*Width +: Width]);
      drv_oe = drv_oe | (sel[i] & req_oe_i[i*Width +: Width]);
    end
  end
  assign owned_mask_o = owned;
  assign gpio_out_o = (sw_out_i & ~owned) | drv_out;
  assign gpio_oe_o = (sw_oe_i & ~owned) | drv_oe;
endmodule

// File: tb/tb_gpio_pin_arbiter.sv
// tb_gpio_pin_arbiter: directed scenarios with hand-computed grants, revokes and pad values
module tb_gpio_pin_arbiter;
  logic clk = 1'b0, rst;
  logic [3:0] req, rel, gnt, revoke;
  logic [127:0] req_mask, req_out, req_oe;
  logic [31:0] sw_out, sw_oe, owned, pad_out, pad_oe;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  gpio_pin_arbiter #(.NumReq(4), .Width(32), .TimeoutCycles(8)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req_mask_i(req_mask), .rel_i(rel),
    .req_out_i(req_out), .req_oe_i(req_oe), .sw_out_i(sw_out), .sw_oe_i(sw_oe),
    .gnt_o(gnt), .revoke_o(revoke), .owned_mask_o(owned),
    .gpio_out_o(pad_out), .gpio_oe_o(pad_oe)
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    cyc();
    rst = 1'b1;
    req = '0;
    rel = '0;
    cyc();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; req = '0; rel = '0; req_mask = '0; req_out = '0; req_oe = '0;
    sw_out = 32'hA5A5_0F0F; sw_oe = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vecs++; if (pad_out !== 32'hA5A5_0F0F) begin errs++; $display("FAIL reset_out: got %h want a5a50f0f", pad_out); end
    vecs++; if (pad_oe !== 32'hFFFF_FFFF) begin errs++; $display("FAIL reset_oe: got %h want ffffffff", pad_oe); end
    vecs++; if (owned !== 32'h0) begin errs++; $display("FAIL reset_owned: got %h want 0", owned); end
    vecs++; if (gnt !== 4'h0 || revoke !== 4'h0) begin errs++; $display("FAIL reset_gnt: got gnt %b revoke %b want 0", gnt, revoke); end
    cyc();
    req[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      vecs++; if (gnt !== 4'h0) begin errs++; $display("FAIL zero_mask_gnt%0d: got %b want 0000", k, gnt); end
    end
    req = '0;
  endtask
  task automatic test_own_release();
    cyc();
    req[0] = 1'b1; req_mask[31:0] = 32'h0000_00FF; req_out[31:0] = 32'hDEAD_BE3C; req_oe[31:0] = 32'h0000_00F0;
    @(negedge clk);
    vecs++; if (gnt !== 4'h0) begin errs++; $display("FAIL own_t0: got %b want 0000", gnt); end
    cyc(); @(negedge clk);
    vecs++; if (gnt !== 4'h0) begin errs++; $display("FAIL own_t1: got %b want 0000", gnt); end
    cyc(); @(negedge clk);
    vecs++; if (gnt !== 4'b0001) begin errs++; $display("FAIL own_t2: got %b want 0001", gnt); end
    vecs++; if (pad_out !== 32'hA5A5_0F3C) begin errs++; $display("FAIL own_out: got %h want a5a50f3c", pad_out); end
    vecs++; if (pad_oe !== 32'hFFFF_FFF0) begin errs++; $display("FAIL own_oe: got %h want fffffff0", pad_oe); end
    vecs++; if (owned !== 32'h0000_00FF) begin errs++; $display("FAIL own_mask: got %h want 000000ff", owned); end
    cyc(); cyc(); cyc();
    rel[0] = 1'b1; req[0] = 1'b0;
    @(negedge clk);
    vecs++; if (gnt !== 4'b0001) begin errs++; $display("FAIL own_t5: got %b want 0001", gnt); end
    cyc();
    rel = '0;
    @(negedge clk);
    vecs++; if (gnt !== 4'h0) begin errs++; $display("FAIL rel_t6: got %b want 0000", gnt); end
    vecs++; if (pad_out !== 32'hA5A5_0F0F || owned !== 32'h0) begin errs++; $display("FAIL rel_pads: got out %h owned %h want a5a50f0f 0", pad_out, owned); end
    cyc();
    req[0] = 1'b1;
    cyc();
    req[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(); @(negedge clk);
      vecs++; if (gnt !== 4'h0) begin errs++; $display("FAIL withdraw_gnt%0d: got %b want 0000", k, gnt); end
    end
  endtask
  task automatic test_disjoint();
    do_reset();
    cyc();
    req = 4'b0011;
    req_mask[31:0] = 32'h0000_000F; req_out[31:0] = 32'h1234_567A; req_oe[31:0] = 32'h0000_0005;
    req_mask[63:32] = 32'h0000_00F0; req_out[63:32] = 32'h8765_4331; req_oe[63:32] = 32'hFFFF_FF0F;
    cyc(); @(negedge clk);
    vecs++; if (gnt !== 4'h0) begin errs++; $display("FAIL dj_c1: got %b want 0000", gnt); end
    cyc(); @(negedge clk);
    vecs++; if (gnt !== 4'b0001) begin errs++; $display("FAIL dj_c2: got %b want 0001", gnt); end
    cyc(); @(negedge clk);
    vecs++; if (gnt !== 4'b0011) begin errs++; $display("FAIL dj_c3: got %b want 0011", gnt); end
    vecs++; if (owned !== 32'h0000_00FF) begin errs++; $display("FAIL dj_owned: got %h want 000000ff", owned); end
    vecs++; if (pad_out !== 32'hA5A5_0F3A || pad_oe !== 32'hFFFF_FF05) begin errs++; $display("FAIL dj_pads: got %h/%h want a5a50f3a/ffffff05", pad_out, pad_oe); end
    cyc();
    rel = 4'b0011; req = '0;
    cyc();
    rel = '0;
    @(negedge clk);
    vecs++; if (gnt !== 4'h0 || owned !== 32'h0) begin errs++; $display("FAIL dj_rel: got %b/%h want 0000/0", gnt, owned); end
  endtask
  task automatic test_overlap();
    cyc();
    req = 4'b0110;
    req_mask[63:32] = 32'h1; req_out[63:32] = 32'h0;
    req_mask[95:64] = 32'h1; req_out[95:64] = 32'h0; req_oe[95:64] = 32'hFFFF_FFFF;
    cyc(); @(negedge clk);
    vecs++; if (gnt !== 4'h0) begin errs++; $display("FAIL ov_c1: got %b want 0000", gnt); end
    cyc(); @(negedge clk);
    vecs++; if (gnt !== 4'b0100) begin errs++; $display("FAIL ov_c2: got %b want 0100", gnt); end
    vecs++; if (owned !== 32'h1 || pad_out !== 32'hA5A5_0F0E) begin errs++; $display("FAIL ov_pads: got owned %h out %h want 1 a5a50f0e", owned, pad_out); end
    cyc(); @(negedge clk);
    vecs++; if (gnt !== 4'b0100) begin errs++; $display("FAIL ov_c3: got %b want 0100", gnt); end
    cyc();
    rel[2] = 1'b1; req[2] = 1'b0;
    @(negedge clk);
    vecs++; if (gnt !== 4'b0100) begin errs++; $display("FAIL ov_T: got %b want 0100", gnt); end
    cyc();
    rel = '0;
    @(negedge clk);
    vecs++; if (gnt !== 4'h0 || pad_out !== 32'hA5A5_0F0F) begin errs++; $display("FAIL ov_T1: got %b out %h want 0000 a5a50f0f", gnt, pad_out); end
    cyc(); @(negedge clk);
    vecs++; if (gnt !== 4'b0010 || pad_out !== 32'hA5A5_0F0E) begin errs++; $display("FAIL ov_T2: got %b out %h want 0010 a5a50f0e", gnt, pad_out); end
    cyc();
    rel = 4'b0010; req = '0;
    cyc();
    rel = '0;
    @(negedge clk);
    vecs++; if (gnt !== 4'h0) begin errs++; $display("FAIL ov_end: got %b want 0000", gnt); end
  endtask
  task automatic test_timeout();
    cyc();
    req[3] = 1'b1; req_mask[127:96] = 32'h0000_0F00; req_out[127:96] = 32'h0000_0500; req_oe[127:96] = 32'h0;
    for (int k = 1; k <= 9; k++) begin
      cyc(); @(negedge clk);
      vecs++; if (gnt !== (k >= 2 ? 4'b1000 : 4'b0000) || revoke !== 4'h0) begin errs++; $display("FAIL to_c%0d: got gnt %b revoke %b", k, gnt, revoke); end
      if (k == 2) begin
        vecs++; if (pad_out !== 32'hA5A5_050F || pad_oe !== 32'hFFFF_F0FF) begin errs++; $display("FAIL to_pads: got %h/%h want a5a5050f/fffff0ff", pad_out, pad_oe); end
      end
    end
    cyc(); @(negedge clk);
    vecs++; if (gnt !== 4'h0 || revoke !== 4'b1000) begin errs++; $display("FAIL to_revoke: got gnt %b revoke %b want 0000 1000", gnt, revoke); end
    vecs++; if (pad_out !== 32'hA5A5_0F0F) begin errs++; $display("FAIL to_sw: got %h want a5a50f0f", pad_out); end
    cyc(); @(negedge clk);
    vecs++; if (gnt !== 4'h0 || revoke !== 4'h0) begin errs++; $display("FAIL to_block: got gnt %b revoke %b want 0", gnt, revoke); end
    cyc();
    req[3] = 1'b0;
    @(negedge clk);
    vecs++; if (gnt !== 4'h0) begin errs++; $display("FAIL to_c12: got %b want 0000", gnt); end
    cyc();
    req[3] = 1'b1;
    cyc(); @(negedge clk);
    vecs++; if (gnt !== 4'h0) begin errs++; $display("FAIL to_c14: got %b want 0000", gnt); end
    cyc(); @(negedge clk);
    vecs++; if (gnt !== 4'b1000) begin errs++; $display("FAIL to_regrant: got %b want 1000", gnt); end
    repeat (7) cyc();
    rel[3] = 1'b1;
    @(negedge clk);
    vecs++; if (gnt !== 4'b1000) begin errs++; $display("FAIL to_lastcyc: got %b want 1000", gnt); end
    cyc();
    rel = '0; req = '0;
    @(negedge clk);
    vecs++; if (gnt !== 4'h0 || revoke !== 4'h0) begin errs++; $display("FAIL to_relwins: got gnt %b revoke %b want 0", gnt, revoke); end
    cyc(); @(negedge clk);
    vecs++; if (revoke !== 4'h0) begin errs++; $display("FAIL to_norevoke: got %b want 0000", revoke); end
  endtask
  task automatic test_reset_mid();
    cyc();
    req = 4'b0011;
    req_mask[31:0] = 32'h1; req_out[31:0] = 32'h0; req_oe[31:0] = 32'hFFFF_FFFF;
    req_mask[63:32] = 32'h1;
    cyc(); cyc(); cyc();
    @(negedge clk);
    vecs++; if (gnt !== 4'b0001 || pad_out !== 32'hA5A5_0F0E) begin errs++; $display("FAIL rm_own: got %b out %h want 0001 a5a50f0e", gnt, pad_out); end
    rst = 1'b1;
    #1;
    vecs++; if (gnt !== 4'h0 || owned !== 32'h0) begin errs++; $display("FAIL rm_gnt: got %b owned %h want 0", gnt, owned); end
    vecs++; if (pad_out !== 32'hA5A5_0F0F) begin errs++; $display("FAIL rm_pads: got %h want a5a50f0f", pad_out); end
    req = '0;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc(); @(negedge clk);
      vecs++; if (gnt !== 4'h0) begin errs++; $display("FAIL rm_stale%0d: got %b want 0000", k, gnt); end
    end
    cyc();
    req = 4'b0011;
    cyc(); cyc(); @(negedge clk);
    vecs++; if (gnt !== 4'b0001) begin errs++; $display("FAIL rm_ptr: got %b want 0001", gnt); end
    cyc();
    rel = 4'b0001; req = '0;
    cyc();
    rel = '0;
  endtask
  initial begin
    test_reset();
    test_own_release();
    test_disjoint();
    test_overlap();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
